core_data_exec: RTL and testbench

- Execute-side consumer of the alu_decode bundle produced by the data-processing decoder.
- Takes one decoded data-processing instruction plus register operand values and the current NZCV flags.
- Computes the shifter operand and shifter carry in one registered stage, then the ALU result and new flags in a second.
- Reports completion with a done pulse to the core control FSM.

---
 rtl/core_data_exec_pkg.sv | 60 ++++++
 rtl/core_data_shifter.sv | 59 +++++
 rtl/core_data_exec.sv | 189 ++++++++++++++++++
 tb/tb_core_data_exec.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_data_exec_pkg.sv
// Shared definitions for the data-processing execute slice: decoded
// instruction bundle, ARM ALU opcodes, NZCV bit positions and FSM states.
package core_data_exec_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 8;

    // Decoded data-processing fields handed over by the decoder
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic       snd_is_imm;
        logic       snd_shift_by_reg;
        logic       shl;
        logic       shr;
        logic       ror;
        logic       put_carry;
        logic       sign_extend;
        logic [7:0] imm;
        logic [5:0] shift_imm;
    } alu_decode;

    // ALU opcodes in ARM encoding order
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_RSC = 4'h7;
    localparam logic [3:0] ALU_TST = 4'h8;
    localparam logic [3:0] ALU_TEQ = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;
    localparam logic [3:0] ALU_CMN = 4'hB;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;

    // NZCV bit positions within a 4-bit flags word
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ALU   = 2'd2
    } exec_state_e;

    // Rotate a word right by 0..31
    function automatic logic [XLEN-1:0] ror32(input logic [XLEN-1:0] v, input logic [4:0] r);
        logic [2*XLEN-1:0] dbl;
        dbl = {v, v} >> r;
        return dbl[XLEN-1:0];
    endfunction

endpackage

// File: rtl/core_data_shifter.sv
// Barrel shifter producing the second ALU operand and the shifter carry.
// Ports: decode (latched bundle), rm_value, rs_value[7:0], carry_in (C flag)
//        -> operand[31:0], carry. Purely combinational.
module core_data_shifter
    import core_data_exec_pkg::*;
(
    input  alu_decode         decode,
    input  logic [XLEN-1:0]   rm_value,
    input  logic [SHAMT_W-1:0] rs_value,
    input  logic              carry_in,
    output logic [XLEN-1:0]   operand,
    output logic              carry
);

    logic [SHAMT_W-1:0] amount;
    logic [XLEN-1:0]    imm_rot;
    logic [XLEN-1:0]    reg_rot;
    logic [XLEN:0]      lsl_ext;
    logic [XLEN:0]      lsr_ext;
    logic [XLEN:0]      asr_ext;
    logic               unused_decode;

    assign unused_decode = ^{decode.op, decode.rd};

    // Extra bit beyond the word catches the last bit shifted out; shifts of
    // 33 or more naturally flush both operand and carry to zero (or sign).
    always_comb begin
        amount  = decode.snd_shift_by_reg ? rs_value : SHAMT_W'(decode.shift_imm);
        imm_rot = ror32(XLEN'(decode.imm), decode.shift_imm[4:0]);
        reg_rot = ror32(rm_value, amount[4:0]);
        lsl_ext = {1'b0, rm_value} << amount;
        lsr_ext = {rm_value, 1'b0} >> amount;
        asr_ext = (XLEN+1)'($signed({rm_value, 1'b0}) >>> amount);

        operand = rm_value;
        carry   = carry_in;

        if (decode.snd_is_imm) begin
            operand = imm_rot;
            carry   = (decode.shift_imm[4:0] == 5'd0) ? carry_in : imm_rot[XLEN-1];
        end else if (amount == '0) begin
            operand = rm_value;
            carry   = carry_in;
        end else if (decode.put_carry && (amount == SHAMT_W'(1))) begin
            operand = {carry_in, rm_value[XLEN-1:1]};
            carry   = rm_value[0];
        end else if (decode.ror) begin
            operand = reg_rot;
            carry   = reg_rot[XLEN-1];
        end else if (decode.shr) begin
            operand = decode.sign_extend ? asr_ext[XLEN:1] : lsr_ext[XLEN:1];
            carry   = decode.sign_extend ? asr_ext[0] : lsr_ext[0];
        end else if (decode.shl) begin
            operand = lsl_ext[XLEN-1:0];
            carry   = lsl_ext[XLEN];
        end
    end

endmodule

// File: rtl/core_data_exec.sv
// Execute stage for decoded data-processing instructions.
// Ports: clk, rst (sync, active-high), start/ready handshake, decode bundle,
//        writeback_in, update_flags_in, rn/rm/rs values, flags_in (NZCV)
//        -> done pulse, result, rd, writeback, flags_out, update_flags.
// Sequence: IDLE (latch) -> SHIFT (register operand) -> ALU (register result).
module core_data_exec
    import core_data_exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_decode        decode,
    input  logic             writeback_in,
    input  logic             update_flags_in,
    input  logic [XLEN-1:0]  rn_value,
    input  logic [XLEN-1:0]  rm_value,
    input  logic [XLEN-1:0]  rs_value,
    input  logic [3:0]       flags_in,
    output logic             ready,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [3:0]       rd,
    output logic             writeback,
    output logic [3:0]       flags_out,
    output logic             update_flags
);

    exec_state_e        state_q, state_d;
    alu_decode          dec_q, dec_d;
    logic [XLEN-1:0]    rn_q, rn_d, rm_q, rm_d;
    logic [SHAMT_W-1:0] rs_q, rs_d;
    logic [3:0]         flags_in_q, flags_in_d;
    logic               writeback_q, writeback_d;
    logic               update_flags_q, update_flags_d;
    logic [XLEN-1:0]    shift_op_q, shift_op_d;
    logic               shift_c_q, shift_c_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [3:0]         flags_out_q, flags_out_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic [XLEN-1:0]    sh_operand;
    logic               sh_carry;
    logic               unused_rs_hi;

    assign unused_rs_hi = ^rs_value[XLEN-1:SHAMT_W];

    core_data_shifter u_shifter (
        .decode   (dec_q),
        .rm_value (rm_q),
        .rs_value (rs_q),
        .carry_in (flags_in_q[FLAG_C]),
        .operand  (sh_operand),
        .carry    (sh_carry)
    );

    // ALU: every arithmetic op is x + y + ci with operands swapped/inverted
    logic [XLEN-1:0] add_x, add_y, alu_res;
    logic            add_ci, arith, alu_v;
    logic [XLEN:0]   sum;
    logic [3:0]      alu_flags;

    always_comb begin
        add_x  = rn_q;
        add_y  = shift_op_q;
        add_ci = 1'b0;
        case (dec_q.op)
            ALU_SUB, ALU_CMP: begin add_y = ~shift_op_q; add_ci = 1'b1; end
            ALU_RSB:          begin add_x = shift_op_q; add_y = ~rn_q; add_ci = 1'b1; end
            ALU_ADC:          begin add_ci = flags_in_q[FLAG_C]; end
            ALU_SBC:          begin add_y = ~shift_op_q; add_ci = flags_in_q[FLAG_C]; end
            ALU_RSC:          begin add_x = shift_op_q; add_y = ~rn_q; add_ci = flags_in_q[FLAG_C]; end
            default:          ;
        endcase
        sum   = (XLEN+1)'(add_x) + (XLEN+1)'(add_y) + (XLEN+1)'(add_ci);
        alu_v = (add_x[XLEN-1] == add_y[XLEN-1]) && (sum[XLEN-1] != add_x[XLEN-1]);

        arith = 1'b0;
        case (dec_q.op)
            ALU_AND, ALU_TST: alu_res = rn_q & shift_op_q;
            ALU_EOR, ALU_TEQ: alu_res = rn_q ^ shift_op_q;
            ALU_ORR:          alu_res = rn_q | shift_op_q;
            ALU_MOV:          alu_res = shift_op_q;
            ALU_BIC:          alu_res = rn_q & ~shift_op_q;
            ALU_MVN:          alu_res = ~shift_op_q;
            default: begin
                alu_res = sum[XLEN-1:0];
                arith   = 1'b1;
            end
        endcase

        alu_flags = flags_in_q;
        if (update_flags_q) begin
            alu_flags[FLAG_N] = alu_res[XLEN-1];
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_C] = arith ? sum[XLEN] : shift_c_q;
            alu_flags[FLAG_V] = arith ? alu_v : flags_in_q[FLAG_V];
        end
    end

    // Next-state and output computation
    always_comb begin
        state_d        = state_q;
        dec_d          = dec_q;
        rn_d           = rn_q;
        rm_d           = rm_q;
        rs_d           = rs_q;
        flags_in_d     = flags_in_q;
        writeback_d    = writeback_q;
        update_flags_d = update_flags_q;
        shift_op_d     = shift_op_q;
        shift_c_d      = shift_c_q;
        result_d       = result_q;
        flags_out_d    = flags_out_q;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dec_d          = decode;
                    rn_d           = rn_value;
                    rm_d           = rm_value;
                    rs_d           = rs_value[SHAMT_W-1:0];
                    flags_in_d     = flags_in;
                    writeback_d    = writeback_in;
                    update_flags_d = update_flags_in;
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_op_d = sh_operand;
                shift_c_d  = sh_carry;
                state_d    = ST_ALU;
            end
            ST_ALU: begin
                result_d    = alu_res;
                flags_out_d = alu_flags;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dec_q          <= '0;
            rn_q           <= '0;
            rm_q           <= '0;
            rs_q           <= '0;
            flags_in_q     <= '0;
            writeback_q    <= 1'b0;
            update_flags_q <= 1'b0;
            shift_op_q     <= '0;
            shift_c_q      <= 1'b0;
            result_q       <= '0;
            flags_out_q    <= '0;
            done_q         <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            dec_q          <= dec_d;
            rn_q           <= rn_d;
            rm_q           <= rm_d;
            rs_q           <= rs_d;
            flags_in_q     <= flags_in_d;
            writeback_q    <= writeback_d;
            update_flags_q <= update_flags_d;
            shift_op_q     <= shift_op_d;
            shift_c_q      <= shift_c_d;
            result_q       <= result_d;
            flags_out_q    <= flags_out_d;
            done_q         <= done_d;
            ready_q        <= ready_d;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign result       = result_q;
    assign rd           = dec_q.rd;
    assign writeback    = writeback_q;
    assign flags_out    = flags_out_q;
    assign update_flags = update_flags_q;

endmodule

// File: tb/tb_core_data_exec.sv
// Self-checking bench for core_data_exec: directed cases plus randomized
// operations compared against a bit-serial shifter / wide-integer ALU model.
module tb_core_data_exec;
    import core_data_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    alu_decode   decode;
    logic        writeback_in, update_flags_in;
    logic [31:0] rn_value, rm_value, rs_value;
    logic [3:0]  flags_in;
    logic        ready, done, writeback, update_flags;
    logic [31:0] result;
    logic [3:0]  rd, flags_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_data_exec dut (
        .clk(clk), .rst(rst), .start(start), .decode(decode),
        .writeback_in(writeback_in), .update_flags_in(update_flags_in),
        .rn_value(rn_value), .rm_value(rm_value), .rs_value(rs_value),
        .flags_in(flags_in), .ready(ready), .done(done), .result(result),
        .rd(rd), .writeback(writeback), .flags_out(flags_out),
        .update_flags(update_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: shifts done one bit at a time, ALU with 64-bit integers
    function automatic void model(input alu_decode d, input logic [31:0] rn, input logic [31:0] rm,
                                  input logic [31:0] rs, input logic [3:0] fl, input logic uf,
                                  output logic [31:0] res, output logic [3:0] nf);
        logic        cin, sc, c, v, arith;
        logic [31:0] so;
        int          amt;
        longint      ua, ub, ur, sa, sb, sr, ci;
        cin = fl[1];
        so  = rm;
        sc  = cin;
        amt = d.snd_shift_by_reg ? int'(rs[7:0]) : int'(d.shift_imm);
        if (d.snd_is_imm) begin
            so = 32'(d.imm);
            for (int i = 0; i < int'(d.shift_imm[4:0]); i++) so = {so[0], so[31:1]};
            sc = (d.shift_imm[4:0] == 5'd0) ? cin : so[31];
        end else if (amt != 0) begin
            if (d.put_carry && amt == 1) begin
                so = {cin, rm[31:1]};
                sc = rm[0];
            end else if (d.ror) begin
                for (int i = 0; i < amt; i++) so = {so[0], so[31:1]};
                sc = so[31];
            end else if (d.shr) begin
                for (int i = 0; i < amt; i++) begin
                    sc = so[0];
                    so = {d.sign_extend ? so[31] : 1'b0, so[31:1]};
                end
            end else if (d.shl) begin
                for (int i = 0; i < amt; i++) begin
                    sc = so[31];
                    so = {so[30:0], 1'b0};
                end
            end
        end
        ua = longint'(rn); ub = longint'(so);
        sa = longint'($signed(rn)); sb = longint'($signed(so));
        ci = cin ? 64'sd1 : 64'sd0;
        arith = 1'b1; c = sc; v = fl[0]; ur = 0; sr = 0; res = 32'h0;
        case (d.op)
            ALU_AND, ALU_TST: begin res = rn & so;  arith = 1'b0; end
            ALU_EOR, ALU_TEQ: begin res = rn ^ so;  arith = 1'b0; end
            ALU_ORR:          begin res = rn | so;  arith = 1'b0; end
            ALU_MOV:          begin res = so;       arith = 1'b0; end
            ALU_BIC:          begin res = rn & ~so; arith = 1'b0; end
            ALU_MVN:          begin res = ~so;      arith = 1'b0; end
            ALU_SUB, ALU_CMP: begin ur = ua - ub; sr = sa - sb; c = (ua >= ub); end
            ALU_RSB:          begin ur = ub - ua; sr = sb - sa; c = (ub >= ua); end
            ALU_SBC:          begin ur = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); c = (ua >= ub + 1 - ci); end
            ALU_RSC:          begin ur = ub - ua - (1 - ci); sr = sb - sa - (1 - ci); c = (ub >= ua + 1 - ci); end
            ALU_ADD, ALU_CMN: begin ur = ua + ub; sr = sa + sb; c = (ur > 64'sh0FFFFFFFF); end
            default:          begin ur = ua + ub + ci; sr = sa + sb + ci; c = (ur > 64'sh0FFFFFFFF); end
        endcase
        if (arith) begin
            res = 32'(ur);
            v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        nf = uf ? {res[31], (res == 32'h0), c, v} : fl;
    endfunction

    // Issue one op at a negedge and return at the negedge where done is seen
    task automatic do_op(input alu_decode d, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] rs, input logic [3:0] fl, input logic wb,
                         input logic uf, input bit poke_busy, input string tag);
        logic [31:0] er;
        logic [3:0]  ef;
        int          cyc;
        bit          got;
        model(d, rn, rm, rs, fl, uf, er, ef);
        chk({tag, ".ready_in"}, 32'(ready), 32'd1);
        decode = d; rn_value = rn; rm_value = rm; rs_value = rs; flags_in = fl;
        writeback_in = wb; update_flags_in = uf; start = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 8 && !got) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke_busy && cyc < 3) begin
                start = 1'b1;
                decode.op = ~d.op; decode.rd = ~d.rd;
                rn_value = ~rn; rm_value = ~rm; flags_in = ~fl;
                writeback_in = ~wb; update_flags_in = ~uf;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(cyc), 32'd3);
        chk({tag, ".result"}, result, er);
        chk({tag, ".flags"}, 32'(flags_out), 32'(ef));
        chk({tag, ".rd"}, 32'(rd), 32'(d.rd));
        chk({tag, ".wb"}, 32'(writeback), 32'(wb));
        chk({tag, ".uf"}, 32'(update_flags), 32'(uf));
        chk({tag, ".ready_done"}, 32'(ready), 32'd1);
    endtask

    function automatic alu_decode mk(input logic [3:0] op, input logic [3:0] rdn, input int kind,
                                     input logic by_reg, input logic [7:0] imm, input logic [5:0] sh);
        alu_decode d;
        d = '0;
        d.op = op; d.rd = rdn; d.imm = imm; d.shift_imm = sh; d.snd_shift_by_reg = by_reg;
        case (kind)
            0: d.snd_is_imm = 1'b1;
            1: d.shl = 1'b1;
            2: d.shr = 1'b1;
            3: begin d.shr = 1'b1; d.sign_extend = 1'b1; end
            4: d.ror = 1'b1;
            default: begin d.ror = 1'b1; d.put_carry = 1'b1; d.shift_imm = 6'd1; d.snd_shift_by_reg = 1'b0; end
        endcase
        return d;
    endfunction

    function automatic logic [31:0] pick_word();
        logic [31:0] specials [5];
        specials[0] = 32'h0; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h80000000;
        specials[3] = 32'h7FFFFFFF; specials[4] = 32'h1;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return 32'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_decode   d;
        logic [31:0] rs;
        logic [7:0]  amts [7];
        bit          saw_done;
        int          kind;
        amts[0] = 8'd0; amts[1] = 8'd1; amts[2] = 8'd31; amts[3] = 8'd32;
        amts[4] = 8'd33; amts[5] = 8'd255; amts[6] = 8'd16;

        rst = 1'b1; start = 1'b0; decode = '0; writeback_in = 1'b0; update_flags_in = 1'b0;
        rn_value = '0; rm_value = '0; rs_value = '0; flags_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ready", 32'(ready), 32'd1);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.result", result, 32'h0);
        chk("reset.flags", 32'(flags_out), 32'h0);
        chk("reset.rd_wb_uf", 32'({rd, writeback, update_flags}), 32'h0);

        // MOV r0, #0xFF ror 8
        do_op(mk(ALU_MOV, 4'd0, 0, 1'b0, 8'hFF, 6'd8), 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1, 0, "mov_imm");
        chk("mov_imm.const", result, 32'hFF000000);
        chk("mov_imm.nzcv", 32'(flags_out), 32'h0000000A);
        // ADDS overflow into sign bit
        do_op(mk(ALU_ADD, 4'd1, 1, 1'b0, 8'h0, 6'd0), 32'h7FFFFFFF, 32'h1, 32'h0, 4'b0000, 1'b1, 1'b1, 0, "adds");
        chk("adds.const", result, 32'h80000000);
        chk("adds.nzcv", 32'(flags_out), 32'h00000009);
        do_op(mk(ALU_SUB, 4'd2, 1, 1'b0, 8'h0, 6'd0), 32'd5, 32'd5, 32'h0, 4'b0000, 1'b1, 1'b1, 0, "subs");
        chk("subs.nzcv", 32'(flags_out), 32'h00000006);
        do_op(mk(ALU_CMP, 4'd3, 1, 1'b0, 8'h0, 6'd0), 32'd3, 32'd5, 32'h0, 4'b0000, 1'b0, 1'b1, 0, "cmp");
        chk("cmp.nzcv", 32'(flags_out), 32'h00000008);
        // Shift by register, Rs=32 / 33
        do_op(mk(ALU_MOV, 4'd4, 2, 1'b1, 8'h0, 6'd0), 32'h0, 32'h80000001, 32'd32, 4'b0000, 1'b1, 1'b1, 0, "lsr32");
        chk("lsr32.const", 32'({result, flags_out[1]}), 32'({32'h0, 1'b1}));
        do_op(mk(ALU_MOV, 4'd4, 3, 1'b1, 8'h0, 6'd0), 32'h0, 32'h80000001, 32'd32, 4'b0000, 1'b1, 1'b1, 0, "asr32");
        chk("asr32.const", result, 32'hFFFFFFFF);
        chk("asr32.c", 32'(flags_out[1]), 32'd1);
        do_op(mk(ALU_MOV, 4'd4, 4, 1'b1, 8'h0, 6'd0), 32'h0, 32'h80000001, 32'd32, 4'b0000, 1'b1, 1'b1, 0, "ror32");
        chk("ror32.const", result, 32'h80000001);
        chk("ror32.c", 32'(flags_out[1]), 32'd1);
        do_op(mk(ALU_MOV, 4'd4, 1, 1'b1, 8'h0, 6'd0), 32'h0, 32'h80000001, 32'd33, 4'b0010, 1'b1, 1'b1, 0, "lsl33");
        chk("lsl33.nzcv", 32'(flags_out), 32'h00000004);
        // RRX and LSL #0 carry passthrough
        do_op(mk(ALU_MOV, 4'd5, 5, 1'b0, 8'h0, 6'd1), 32'h0, 32'h3, 32'h0, 4'b0010, 1'b1, 1'b1, 0, "rrx");
        chk("rrx.const", result, 32'h80000001);
        chk("rrx.nzcv", 32'(flags_out), 32'h0000000A);
        do_op(mk(ALU_MOV, 4'd6, 1, 1'b0, 8'h0, 6'd0), 32'h0, 32'h12345678, 32'h0, 4'b0010, 1'b1, 1'b1, 0, "lsl0");
        chk("lsl0.nzcv", 32'(flags_out), 32'h00000002);
        // Start while busy is ignored
        do_op(mk(ALU_ADC, 4'd7, 2, 1'b0, 8'h0, 6'd4), 32'h10, 32'hF0, 32'h0, 4'b0010, 1'b1, 1'b1, 1, "busy");
        chk("busy.const", result, 32'h20);
        @(negedge clk);
        chk("busy.no_second", 32'({done, ready}), 32'b01);
        chk("busy.held", result, 32'h20);

        // Reset in SHIFT aborts
        decode = mk(ALU_MVN, 4'd9, 1, 1'b0, 8'h0, 6'd3); rm_value = 32'h5; start = 1'b1;
        writeback_in = 1'b1; update_flags_in = 1'b1; flags_in = 4'hF;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.outs", 32'({done, writeback, update_flags, rd, flags_out}), 32'h0);
        chk("abort.result", result, 32'h0);
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort.no_done", 32'(saw_done), 32'd0);

        // Randomized ops, issued back to back (start in done cycle) or with gaps
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 5);
            rs = pick_word();
            if ($urandom_range(0, 1) == 1) rs[7:0] = amts[$urandom_range(0, 6)];
            d = mk(4'($urandom_range(0, 15)), 4'($urandom), kind, 1'($urandom), 8'($urandom),
                   (kind == 0) ? 6'(2 * $urandom_range(0, 15)) : 6'($urandom_range(0, 32)));
            do_op(d, pick_word(), pick_word(), rs, 4'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), "rand");
            if ($urandom_range(0, 2) == 0) begin
                logic [31:0] held;
                held = result;
                @(negedge clk);
                chk("rand.idle_done", 32'(done), 32'd0);
                chk("rand.held", result, held);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
